// File: rtl/instr_fetch_unit_if.sv
// Bundle between the fetch unit, the byte-wide instruction memory and the core.
// The fetch unit is the master: it issues memory requests and presents instructions.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 13
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              misalign_err;

    modport master (
        output mem_req, mem_addr, inst_valid, inst_data, inst_pc, misalign_err,
        input  mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst_data, inst_pc, misalign_err,
        output mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch with a small prefetch FIFO and redirect support.
// State | meaning: IDLE | waiting for FIFO room / no error; FETCH | reading bytes; PUSH | word into FIFO
module instr_fetch_unit #(
    parameter int                 ADDR_W     = 13,
    parameter int                 FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, PUSH} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [1:0]        r_byte_idx;
    logic [31:0]       r_word;
    logic              r_misalign;
    logic [31:0]       r_fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic [CNT_W-1:0]  w_count_next;

    assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push = (r_state == PUSH);
    assign w_pop  = (r_count != '0) && bus.inst_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_misalign <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (bus.redirect) begin
            // Flush wins over any push, pop or memory ack in the same cycle
            r_state    <= IDLE;
            r_fetch_pc <= bus.redirect_pc;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_misalign <= |bus.redirect_pc[1:0];
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (!w_full && !r_misalign) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.mem_ack) begin
                        r_word[{r_byte_idx, 3'b000} +: 8] <= bus.mem_rdata;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_state <= PUSH;
                        end
                    end
                end
                PUSH: begin
                    r_fifo_data[r_wr_ptr] <= r_word;
                    r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
                    r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
                    r_byte_idx <= '0;
                    r_state    <= (w_count_next == CNT_W'(FIFO_DEPTH)) ? IDLE : FETCH;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req      = (r_state == FETCH);
    assign bus.mem_addr     = r_fetch_pc + ADDR_W'(r_byte_idx);
    assign bus.inst_valid   = (r_count != '0);
    assign bus.inst_data    = r_fifo_data[r_rd_ptr];
    assign bus.inst_pc      = r_fifo_pc[r_rd_ptr];
    assign bus.misalign_err = r_misalign;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: byte memory model with wait states and a
// simple consumer that checks every delivered instruction against the memory image.
module tb_instr_fetch_unit;
    localparam int ADDR_W = 13;
    localparam int MASK   = (1 << ADDR_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [7:0] mem [1 << ADDR_W];
    int wait_states = 0;
    int wait_cnt    = 0;
    int n_checks    = 0;
    int n_errors    = 0;
    int exp_pc      = 0;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    instr_fetch_unit #(.ADDR_W(ADDR_W), .FIFO_DEPTH(2), .RESET_PC('0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.mem_ack   = bus.mem_req && (wait_cnt >= wait_states);
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        wait_cnt <= (bus.mem_req && !bus.mem_ack) ? wait_cnt + 1 : 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int pc);
        return {mem[(pc + 3) & MASK], mem[(pc + 2) & MASK], mem[(pc + 1) & MASK], mem[pc & MASK]};
    endfunction

    task automatic do_redirect(input int pc);
        @(negedge clk);
        bus.redirect    = 1'b1;
        bus.redirect_pc = ADDR_W'(pc);
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
    endtask

    // Consume with ready=1; each delivered entry must follow exp_pc in order.
    task automatic drain(input int cycles, input int max_pops, output int pops);
        logic              p_req;
        logic              p_ack;
        logic [ADDR_W-1:0] p_addr;
        pops   = 0;
        p_req  = 1'b0;
        p_ack  = 1'b0;
        p_addr = '0;
        bus.inst_ready = 1'b1;
        for (int c = 0; c < cycles && pops < max_pops; c++) begin
            @(negedge clk);
            if (p_req && !p_ack) begin
                check("req_hold", 32'(bus.mem_req), 32'd1);
                check("addr_hold", 32'(bus.mem_addr), 32'(p_addr));
            end
            if (bus.inst_valid) begin
                check("inst_pc", 32'(bus.inst_pc), 32'(exp_pc));
                check("inst_data", bus.inst_data, word_at(exp_pc));
                exp_pc = (exp_pc + 4) & MASK;
                pops++;
            end
            p_req  = bus.mem_req;
            p_ack  = bus.mem_ack;
            p_addr = bus.mem_addr;
        end
        @(posedge clk);
        #1;
        bus.inst_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        int pops;
        bit found;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'((i * 7 + 3) ^ (i >> 5));
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
        mem[4] = 8'h93; mem[5] = 8'h05; mem[6] = 8'h20; mem[7] = 8'h00;

        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready  = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_data", bus.inst_data, 32'd0);
        check("rst_pc", 32'(bus.inst_pc), 32'd0);
        check("rst_err", 32'(bus.misalign_err), 32'd0);

        // First instruction latency and content
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        while (!bus.inst_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("first_valid_cycle", 32'(cyc), 32'd6);
        check("first_pc", 32'(bus.inst_pc), 32'h0);
        check("first_data", bus.inst_data, 32'h00100513);
        exp_pc = 0;
        drain(40, 2, pops);
        check("t1_pops", 32'(pops), 32'd2);
        check("t1_last_pc", 32'(exp_pc), 32'd8);

        // Backpressure: FIFO fills to depth and fetching stops
        repeat (30) @(posedge clk);
        #1;
        check("full_req", 32'(bus.mem_req), 32'd0);
        check("full_valid", 32'(bus.inst_valid), 32'd1);
        check("full_head_pc", 32'(bus.inst_pc), 32'h8);
        drain(3, 10, pops);
        check("full_count", 32'(pops), 32'd2);
        drain(60, 5, pops);
        check("stream_pops", 32'(pops), 32'd5);

        // Wait-state memory
        wait_states = 3;
        drain(150, 3, pops);
        check("wait_pops", 32'(pops), 32'd3);
        wait_states = 0;

        // Redirect on the second byte ack while an entry is queued
        do_redirect(32'h80);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_ack && bus.mem_addr == ADDR_W'(32'h85)) found = 1'b1;
        end
        check("redir_found", 32'(found), 32'd1);
        check("redir_prequeued", 32'(bus.inst_valid), 32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = ADDR_W'(32'h40);
        bus.inst_ready  = 1'b1;
        @(posedge clk);
        #1;
        bus.redirect   = 1'b0;
        bus.inst_ready = 1'b0;
        check("redir_flush", 32'(bus.inst_valid), 32'd0);
        check("redir_idle_req", 32'(bus.mem_req), 32'd0);
        check("redir_addr", 32'(bus.mem_addr), 32'h40);
        @(posedge clk);
        #1;
        check("redir_req", 32'(bus.mem_req), 32'd1);
        check("redir_first_addr", 32'(bus.mem_addr), 32'h40);
        exp_pc = 32'h40;
        drain(40, 2, pops);
        check("redir_pops", 32'(pops), 32'd2);

        // Misaligned redirect halts; an aligned one recovers
        do_redirect(32'h42);
        check("mis_err", 32'(bus.misalign_err), 32'd1);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            check("mis_req", 32'(bus.mem_req), 32'd0);
        end
        check("mis_valid", 32'(bus.inst_valid), 32'd0);
        do_redirect(32'h44);
        check("mis_clear", 32'(bus.misalign_err), 32'd0);
        check("mis_resume_addr", 32'(bus.mem_addr), 32'h44);
        exp_pc = 32'h44;
        drain(40, 1, pops);
        check("mis_pops", 32'(pops), 32'd1);

        // PC wraps at the top of the address space
        do_redirect(32'h1FFC);
        exp_pc = 32'h1FFC;
        drain(40, 2, pops);
        check("wrap_pops", 32'(pops), 32'd2);
        check("wrap_next_pc", 32'(exp_pc), 32'h4);

        // Reset in the middle of a word restarts cleanly from the reset PC
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_addr[1:0] == 2'd2) found = 1'b1;
        end
        check("midrst_found", 32'(found), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_valid", 32'(bus.inst_valid), 32'd0);
        check("midrst_addr", 32'(bus.mem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        exp_pc = 0;
        drain(40, 1, pops);
        check("midrst_pops", 32'(pops), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
